// File: rtl/rho_pkg.sv
// Shared types and constants for the rho rotate engine and its lane rotator.
package rho_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROT  = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/lane_rotator.sv
// Combinational barrel rotator for one W-bit lane; left or right by amt_i.
module lane_rotator
    import rho_pkg::*;
#(
    parameter int unsigned W = 64,
    localparam int unsigned LW = $clog2(W)
) (
    input  logic [W-1:0]  data_i,
    input  logic [LW-1:0] amt_i,
    input  logic          dir_i,
    output logic [W-1:0]  data_o
);

    logic [LW-1:0]  left_amt;
    logic [2*W-1:0] dbl;

    // A right rotate by o is a left rotate by (W-o) mod W; LW-bit wrap gives the mod.
    always_comb begin
        left_amt = (dir_i == DIR_RIGHT) ? (LW'(0) - amt_i) : amt_i;
        dbl      = {data_i, data_i} << left_amt;
        data_o   = dbl[2*W-1:W];
    end

endmodule

// File: rtl/rho_rotate_engine.sv
// Loads N lanes, rotates lane k by k(k+1)/2 mod W (one lane per cycle), streams them out.
module rho_rotate_engine
    import rho_pkg::*;
#(
    parameter int unsigned W = 64,
    parameter int unsigned N = 25,
    localparam int unsigned LW = $clog2(W),
    localparam int unsigned NW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dir,
    output logic         ready,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         out_last,
    output logic         done
);

    state_e        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] off_q, off_d;
    logic          dir_q, dir_d;
    logic          done_q, done_d;

    logic [W-1:0]  mem_q [N];
    logic          mem_we;
    logic [W-1:0]  mem_wdata;

    logic [W-1:0]  rd_lane;
    logic [W-1:0]  rot_lane;
    logic          last_lane;

    assign rd_lane   = mem_q[cnt_q];
    assign last_lane = (cnt_q == NW'(N - 1));

    lane_rotator #(.W(W)) u_rot (
        .data_i (rd_lane),
        .amt_i  (off_q),
        .dir_i  (dir_q),
        .data_o (rot_lane)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            dir_q   <= DIR_LEFT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Lane storage is deliberately not reset; every block rewrites all N lanes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cnt_q] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = in_data;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    cnt_d   = '0;
                    off_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = in_data;
                    if (last_lane) begin
                        cnt_d   = '0;
                        state_d = ROT;
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end
            end
            ROT: begin
                mem_we    = 1'b1;
                mem_wdata = rot_lane;
                // Running triangular sum; truncation to LW bits is the mod W.
                off_d     = LW'(32'(off_q) + 32'(cnt_q) + 32'd1);
                if (last_lane) begin
                    cnt_d   = '0;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (last_lane) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == OUT);
    assign out_data  = rd_lane;
    assign out_last  = (state_q == OUT) && last_lane;
    assign done      = done_q;

endmodule

// File: tb/tb_rho_rotate_engine.sv
// Scoreboard bench: two engine instances (8x5 and 64x25) driven with directed blocks.
module tb_rho_rotate_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start8, dir8, ready8, in_valid8, in_ready8;
    logic        out_valid8, out_ready8, out_last8, done8;
    logic [7:0]  in_data8, out_data8;

    logic        start64, dir64, ready64, in_valid64, in_ready64;
    logic        out_valid64, out_ready64, out_last64, done64;
    logic [63:0] in_data64, out_data64;

    rho_rotate_engine #(.W(8), .N(5)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .dir(dir8), .ready(ready8),
        .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready8),
        .out_last(out_last8), .done(done8)
    );

    rho_rotate_engine #(.W(64), .N(25)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .dir(dir64), .ready(ready64),
        .in_valid(in_valid64), .in_data(in_data64), .in_ready(in_ready64),
        .out_valid(out_valid64), .out_data(out_data64), .out_ready(out_ready64),
        .out_last(out_last64), .done(done64)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int s);
        int m;
        m = s % 64;
        if (m == 0) return x;
        return (x << m) | (x >> (64 - m));
    endfunction

    function automatic int tri_off(input int k, input int w);
        return ((k * (k + 1)) / 2) % w;
    endfunction

    // Monitor for the 8x5 instance
    logic        exp_done8 = 1'b0, stalled8 = 1'b0, held_last8;
    logic [7:0]  held8;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            exp_done8 = 1'b0;
            stalled8  = 1'b0;
        end else begin
            if (exp_done8) begin
                check("done_ready8", {62'd0, done8, ready8}, 64'd3);
                exp_done8 = 1'b0;
            end else if (done8) begin
                check("spurious_done8", done8, 0);
            end
            if (out_valid8 && stalled8) begin
                check("hold_data8", out_data8, held8);
                check("hold_last8", out_last8, held_last8);
            end
            if (out_valid8 && !out_ready8) begin
                stalled8   = 1'b1;
                held8      = out_data8;
                held_last8 = out_last8;
            end else begin
                stalled8 = 1'b0;
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    check("extra_out8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("data8", out_data8, e.data);
                    check("last8", out_last8, e.last);
                    if (e.last) exp_done8 = 1'b1;
                end
            end
        end
    end

    // Monitor for the 64x25 instance
    logic exp_done64 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            exp_done64 = 1'b0;
        end else begin
            if (exp_done64) begin
                check("done_ready64", {62'd0, done64, ready64}, 64'd3);
                exp_done64 = 1'b0;
            end else if (done64) begin
                check("spurious_done64", done64, 0);
            end
            if (out_valid64 && out_ready64) begin
                if (q64.size() == 0) begin
                    check("extra_out64", 1, 0);
                end else begin
                    e = q64.pop_front();
                    check("data64", out_data64, e.data);
                    check("last64", out_last64, e.last);
                    if (e.last) exp_done64 = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready8();
        int budget = 0;
        while (!ready8 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("ready8_wait", ready8, 1);
    endtask

    task automatic run8(input logic [7:0] lanes [5], input logic [7:0] exp [5], input logic d,
                        input bit gaps, input int stall_lane, input bit poke);
        int  i, lane, stalls, budget, t_last;
        bit  ph, v, first;
        for (int k = 0; k < 5; k++) q8.push_back('{data: 64'(exp[k]), last: (k == 4)});
        wait_ready8();
        start8 = 1'b1; dir8 = d;
        @(posedge clk); #1;
        start8 = 1'b0;
        i = 0; ph = 1'b1; budget = 0;
        while (i < 5 && budget < 100) begin
            v = gaps ? ph : 1'b1;
            ph = ~ph;
            in_valid8 = v;
            in_data8  = v ? lanes[i] : 8'hEE;
            start8    = poke && (i == 2);
            @(posedge clk); #1;
            budget++;
            if (v) i++;
        end
        in_valid8 = 1'b0; start8 = 1'b0; t_last = cyc;
        lane = 0; stalls = 0; first = 1'b0; budget = 0;
        while (lane < 5 && budget < 200) begin
            v = out_valid8;
            if (v && !first) begin
                first = 1'b1;
                check("rot_len8", 64'(cyc - t_last), 64'd5);
            end
            if (v && lane == stall_lane && stalls < 3) begin
                out_ready8 = 1'b0;
                stalls++;
            end else begin
                out_ready8 = 1'b1;
            end
            start8    = poke && (!v || lane == 1);
            in_valid8 = poke && v;
            in_data8  = 8'hFF;
            if (poke && v) check("in_ready_in_out8", in_ready8, 0);
            @(posedge clk); #1;
            budget++;
            if (v && out_ready8) lane++;
        end
        if (lane < 5) check("out_timeout8", 64'(lane), 64'd5);
        in_valid8 = 1'b0; start8 = 1'b0; out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("q8_drained", 64'(q8.size()), 64'd0);
    endtask

    task automatic run64(input logic [63:0] lanes [25], input logic [63:0] exp [25], input logic d);
        int  lane, budget;
        bit  v;
        for (int k = 0; k < 25; k++) q64.push_back('{data: exp[k], last: (k == 24)});
        budget = 0;
        while (!ready64 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("ready64_wait", ready64, 1);
        start64 = 1'b1; dir64 = d;
        @(posedge clk); #1;
        start64 = 1'b0;
        for (int k = 0; k < 25; k++) begin
            in_valid64 = 1'b1;
            in_data64  = lanes[k];
            @(posedge clk); #1;
        end
        in_valid64 = 1'b0;
        lane = 0; budget = 0;
        while (lane < 25 && budget < 200) begin
            v = out_valid64;
            @(posedge clk); #1;
            budget++;
            if (v) lane++;
        end
        if (lane < 25) check("out_timeout64", 64'(lane), 64'd25);
        @(posedge clk); #1;
        check("q64_drained", 64'(q64.size()), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a8 [5];
        logic [7:0]  e8 [5];
        logic [63:0] a64 [25];
        logic [63:0] e64 [25];
        logic [63:0] f64 [25];

        rst = 1'b0;
        start8 = 1'b0; dir8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
        start64 = 1'b0; dir64 = 1'b0; in_valid64 = 1'b0; in_data64 = '0; out_ready64 = 1'b1;
        #2;
        check("rst_ready8", ready8, 1);
        check("rst_in_ready8", in_ready8, 0);
        check("rst_out_valid8", out_valid8, 0);
        check("rst_out_last8", out_last8, 0);
        check("rst_done8", done8, 0);
        check("rst_ready64", ready64, 1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // All lanes 0x81, left then right
        a8 = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        e8 = '{8'h81, 8'h03, 8'h0C, 8'h60, 8'h06};
        run8(a8, e8, 1'b0, 1'b0, -1, 1'b0);
        e8 = '{8'h81, 8'hC0, 8'h30, 8'h06, 8'h60};
        run8(a8, e8, 1'b1, 1'b0, -1, 1'b0);

        // Single set bit per 64-bit lane
        for (int k = 0; k < 25; k++) begin
            a64[k] = 64'h1;
            e64[k] = 64'h1 << tri_off(k, 64);
        end
        e64[1]  = 64'h2;
        e64[3]  = 64'h40;
        e64[24] = 64'h0000_1000_0000_0000;
        run64(a64, e64, 1'b0);

        // Round trip: forward then inverse must restore the block
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 25; k++) begin
                a64[k] = {$urandom(), $urandom()};
                f64[k] = rotl64(a64[k], tri_off(k, 64));
            end
            run64(a64, f64, 1'b0);
            run64(f64, a64, 1'b1);
        end

        // Input gaps and a 3-cycle stall on lane 2
        a8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        e8 = '{8'h01, 8'h04, 8'h20, 8'h02, 8'h40};
        run8(a8, e8, 1'b0, 1'b1, 2, 1'b0);

        // Stray start / in_valid while busy
        a8 = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        e8 = '{8'h81, 8'h03, 8'h0C, 8'h60, 8'h06};
        run8(a8, e8, 1'b0, 1'b0, -1, 1'b1);

        // Reset in the middle of ROT
        wait_ready8();
        start8 = 1'b1; dir8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid8 = 1'b1;
            in_data8  = 8'h5A;
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_ready8", ready8, 1);
        check("abort_out_valid8", out_valid8, 0);
        check("abort_done8", done8, 0);
        @(posedge clk); #1;
        check("abort_ready8_next", ready8, 1);
        check("abort_out_valid8_next", out_valid8, 0);
        check("abort_done8_next", done8, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        a8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        e8 = '{8'h01, 8'h04, 8'h20, 8'h02, 8'h40};
        run8(a8, e8, 1'b0, 1'b0, -1, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
